// File: rtl/div_pkg.sv
// Shared types and sizing for the 16/8 sequential restoring divider.
package div_pkg;

    localparam int W     = 8;
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        LOAD    = 2'b01,
        CALC    = 2'b10,
        DONE_ST = 2'b11
    } state_t;

endpackage

// File: rtl/divider16by8_fd.sv
// Datapath for the restoring divider: operand, partial remainder, shift and result registers.
// DIV_OVF_CHECK_EN enables overflow / divide-by-zero detection at load time.
module divider16by8_fd
    import div_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    input  logic           i_load,
    input  logic           i_iter,
    input  logic           i_commit,
    input  logic [2*W-1:0] i_x,
    input  logic [W-1:0]   i_y,
    output logic           o_ovf,
    output logic [W-1:0]   o_quotient,
    output logic [W-1:0]   o_remainder
);

    logic [W-1:0] r_y;
    logic [W:0]   r_p;
    logic [W-1:0] r_s;
    logic [W-1:0] r_qr;
    logic [W-1:0] r_quot;
    logic [W-1:0] r_rem;
    logic         r_ovf;

    logic [W:0]   w_shift;
    logic [W+1:0] w_t;
    logic         w_ge;
    logic [W:0]   w_p_nxt;
    logic [W-1:0] w_q_nxt;
    logic         w_ovf_det;

    // Extra top bit keeps the borrow separate from the 9-bit shifted value.
    assign w_shift = {r_p[W-1:0], r_s[W-1]};
    assign w_t     = {1'b0, w_shift} - {2'b00, r_y};
    assign w_ge    = ~w_t[W+1];
    assign w_p_nxt = w_ge ? w_t[W:0] : w_shift;
    assign w_q_nxt = {r_qr[W-2:0], w_ge};

`ifdef DIV_OVF_CHECK_EN
    assign w_ovf_det = (i_x[2*W-1:W] >= i_y);
`else
    assign w_ovf_det = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_y    <= '0;
            r_p    <= '0;
            r_s    <= '0;
            r_qr   <= '0;
            r_quot <= '0;
            r_rem  <= '0;
            r_ovf  <= 1'b0;
        end else begin
            if (i_load) begin
                r_y   <= i_y;
                r_p   <= {1'b0, i_x[2*W-1:W]};
                r_s   <= i_x[W-1:0];
                r_qr  <= '0;
                r_ovf <= w_ovf_det;
            end
            if (i_iter) begin
                r_p  <= w_p_nxt;
                r_s  <= {r_s[W-2:0], 1'b0};
                r_qr <= w_q_nxt;
            end
            if (i_commit) begin
                if (r_ovf) begin
                    r_quot <= '1;
                    r_rem  <= '0;
                end else begin
                    r_quot <= w_q_nxt;
                    r_rem  <= w_p_nxt[W-1:0];
                end
            end
        end
    end

    assign o_ovf       = r_ovf;
    assign o_quotient  = r_quot;
    assign o_remainder = r_rem;

endmodule

// File: rtl/divider16by8_seq.sv
// Sequential 16/8 restoring divider: control FSM driving the divider16by8_fd datapath.
// Build with DIV_OVF_CHECK_EN to flag overflow / divide-by-zero via ERR.
module divider16by8_seq
    import div_pkg::*;
(
    input  logic           CLK,
    input  logic           RESET_N,
    input  logic           start,
    input  logic [2*W-1:0] x,
    input  logic [W-1:0]   y,
    output logic [W-1:0]   quotient,
    output logic [W-1:0]   remainder,
    output logic           BUSY,
    output logic           DONE,
    output logic           ERR
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic             w_load;
    logic             w_iter;
    logic             w_commit;
    logic             w_ovf;
    logic             w_last;

    assign w_last   = (r_cnt == CNT_W'(W-1));
    assign w_load   = (r_state == LOAD);
    // An overflowing operation spends a single CALC cycle committing the saturated result.
    assign w_iter   = (r_state == CALC) && !w_ovf;
    assign w_commit = (r_state == CALC) && (w_ovf || w_last);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start) w_state_nxt = LOAD;
            LOAD:    w_state_nxt = CALC;
            CALC:    if (w_commit) w_state_nxt = DONE_ST;
            DONE_ST: w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load)
                r_cnt <= '0;
            else if (w_iter)
                r_cnt <= r_cnt + 1'b1;
        end
    end

    divider16by8_fd u_fd (
        .clk         (CLK),
        .rst_n       (RESET_N),
        .i_load      (w_load),
        .i_iter      (w_iter),
        .i_commit    (w_commit),
        .i_x         (x),
        .i_y         (y),
        .o_ovf       (w_ovf),
        .o_quotient  (quotient),
        .o_remainder (remainder)
    );

    assign BUSY = (r_state != IDLE);
    assign DONE = (r_state == DONE_ST);
    assign ERR  = DONE && w_ovf;

endmodule

// File: tb/tb_divider16by8_seq.sv
// Directed + randomized bench for divider16by8_seq against a plain x/y, x%y reference.
module tb_divider16by8_seq;

    logic        CLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic        start = 1'b0;
    logic [15:0] x = '0;
    logic [7:0]  y = '0;
    logic [7:0]  quotient;
    logic [7:0]  remainder;
    logic        BUSY;
    logic        DONE;
    logic        ERR;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    divider16by8_seq dut (
        .CLK       (CLK),
        .RESET_N   (RESET_N),
        .start     (start),
        .x         (x),
        .y         (y),
        .quotient  (quotient),
        .remainder (remainder),
        .BUSY      (BUSY),
        .DONE      (DONE),
        .ERR       (ERR)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Pulse start for one edge, then count edges until DONE is seen.
    task automatic run_op(input logic [15:0] xv, input logic [7:0] yv, input int exp_lat,
                          input logic [7:0] eq, input logic [7:0] er, input logic ee,
                          input bit chk_qr, input string tag);
        int n;
        @(negedge CLK);
        x = xv; y = yv; start = 1'b1;
        @(posedge CLK);
        #1 start = 1'b0;
        n = 0;
        do begin
            @(posedge CLK); #1; n++;
        end while (!DONE && n < 40);
        chk({tag, " latency"}, 32'(n), 32'(exp_lat));
        chk({tag, " err"}, 32'(ERR), 32'(ee));
        if (chk_qr) begin
            chk({tag, " quotient"}, 32'(quotient), 32'(eq));
            chk({tag, " remainder"}, 32'(remainder), 32'(er));
        end
        @(posedge CLK); #1;
        chk({tag, " done pulse"}, 32'(DONE), 32'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int nd, lowcnt, cyc;
        int dt[3];
        int xi, yi, hi;
        logic [7:0] gq, gr;

        // Reset state
        #12;
        chk("reset quotient", 32'(quotient), 0);
        chk("reset remainder", 32'(remainder), 0);
        chk("reset busy", 32'(BUSY), 0);
        chk("reset done", 32'(DONE), 0);
        chk("reset err", 32'(ERR), 0);
        @(negedge CLK);
        RESET_N = 1'b1;

        // Basic directed operations
        run_op(16'd350,  8'd14,  9, 8'd25, 8'd0, 1'b0, 1'b1, "350/14");
        run_op(16'd355,  8'd14,  9, 8'd25, 8'd5, 1'b0, 1'b1, "355/14");
        run_op(16'd4000, 8'd200, 9, 8'd20, 8'd0, 1'b0, 1'b1, "4000/200");
        run_op(16'd0,    8'd7,   9, 8'd0,  8'd0, 1'b0, 1'b1, "0/7");
        run_op(16'hFEFF, 8'd255, 9, 8'd255, 8'd254, 1'b0, 1'b1, "65279/255");
        run_op(16'd255,  8'd1,   9, 8'd255, 8'd0, 1'b0, 1'b1, "255/1");
        run_op(16'd0,    8'd7,   9, 8'd0,  8'd0, 1'b0, 1'b1, "0/7 again");

        // Operand changes and start toggling during CALC are ignored
        @(negedge CLK);
        x = 16'd1000; y = 8'd33; start = 1'b1;
        @(posedge CLK);
        #1 start = 1'b0;
        repeat (3) @(posedge CLK);
        #1 x = 16'hFFFF; y = 8'd1; start = 1'b1;
        chk("calc busy", 32'(BUSY), 1);
        chk("calc quotient held", 32'(quotient), 0);
        @(posedge CLK); #1 start = 1'b0;
        @(posedge CLK); #1 start = 1'b1;
        @(posedge CLK); #1 start = 1'b0;
        nd = 0; gq = '0; gr = '0;
        for (int c = 0; c < 12; c++) begin
            @(posedge CLK); #1;
            if (DONE) begin nd++; gq = quotient; gr = remainder; end
        end
        chk("ignore done count", 32'(nd), 1);
        chk("ignore quotient", 32'(gq), 30);
        chk("ignore remainder", 32'(gr), 10);

        // Back-to-back with start held high
        for (int i = 0; i < 3; i++) dt[i] = -1;
        nd = 0; lowcnt = 0;
        @(negedge CLK);
        x = 16'd255; y = 8'd16; start = 1'b1;
        for (int c = 1; c <= 35; c++) begin
            @(posedge CLK); #1;
            if (!BUSY) lowcnt++;
            if (DONE) begin
                if (nd < 3) dt[nd] = c;
                nd++;
                chk("b2b quotient", 32'(quotient), 15);
                chk("b2b remainder", 32'(remainder), 15);
            end
        end
        start = 1'b0;
        chk("b2b done count", 32'(nd), 3);
        chk("b2b first latency", 32'(dt[0]), 10);
        chk("b2b period 1", 32'(dt[1] - dt[0]), 11);
        chk("b2b period 2", 32'(dt[2] - dt[1]), 11);
        chk("b2b busy low cycles", 32'(lowcnt), 3);
        cyc = 0;
        while (BUSY && cyc < 20) begin @(posedge CLK); #1; cyc++; end
        chk("b2b drain idle", 32'(BUSY), 0);

        // Asynchronous reset in the middle of CALC
        @(negedge CLK);
        x = 16'd5000; y = 8'd77; start = 1'b1;
        @(posedge CLK);
        #1 start = 1'b0;
        repeat (5) @(posedge CLK);
        #2 RESET_N = 1'b0;
        #1;
        chk("midreset quotient", 32'(quotient), 0);
        chk("midreset remainder", 32'(remainder), 0);
        chk("midreset busy", 32'(BUSY), 0);
        chk("midreset done", 32'(DONE), 0);
        chk("midreset err", 32'(ERR), 0);
        nd = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge CLK); #1;
            if (DONE) nd++;
        end
        chk("midreset no done", 32'(nd), 0);
        @(negedge CLK);
        RESET_N = 1'b1;
        run_op(16'd100, 8'd9, 9, 8'd11, 8'd1, 1'b0, 1'b1, "100/9 after reset");

        // Randomized non-overflowing operands vs. plain arithmetic
        for (int i = 0; i < 24; i++) begin
            yi = int'($urandom_range(1, 255));
            hi = int'($urandom_range(0, yi - 1));
            xi = hi * 256 + int'($urandom_range(0, 255));
            run_op(16'(xi), 8'(yi), 9, 8'(xi / yi), 8'(xi % yi), 1'b0, 1'b1, "random");
        end

`ifdef DIV_OVF_CHECK_EN
        run_op(16'd1234,  8'd0,   2, 8'd255, 8'd0, 1'b1, 1'b1, "ovf 1234/0");
        run_op(16'd65535, 8'd255, 2, 8'd255, 8'd0, 1'b1, 1'b1, "ovf 65535/255");
        run_op(16'd355,   8'd14,  9, 8'd25,  8'd5, 1'b0, 1'b1, "post ovf 355/14");
`else
        run_op(16'd1234,  8'd0,   9, 8'd0, 8'd0, 1'b0, 1'b0, "noovf 1234/0");
        run_op(16'd65535, 8'd255, 9, 8'd0, 8'd0, 1'b0, 1'b0, "noovf 65535/255");
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/divider16by8_seq.md
Name: divider16by8_seq

Overview:
- Sequential restoring divider: 16-bit dividend x, 8-bit divisor y, producing an 8-bit quotient and an 8-bit remainder.
- Inverse companion of the 8-bit multiplier. Dividing a multiplier product by one of its factors recovers the other factor.
- Control FSM plus shift/subtract datapath, with a level start and a one-cycle DONE handshake.

Parameters:
- W, 8, divisor/quotient/remainder width; dividend is 2*W bits.
- CNT_W, 4, iteration counter width; must satisfy 2^CNT_W > W.

Ports:
- CLK  in  1  system clock; all state changes on the rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- start  in  1  level request, sampled only in IDLE.
- x  in  2*W  dividend, sampled on the LOAD edge.
- y  in  W  divisor, sampled on the LOAD edge.
- quotient  out  W  registered result.
- remainder  out  W  registered result.
- BUSY  out  1  high in LOAD, CALC and DONE_ST.
- DONE  out  1  one-cycle completion pulse.
- ERR  out  1  overflow/divide-by-zero flag, valid while DONE=1.

Behaviour:
- Reset (RESET_N=0, asynchronous, any state):
  - FSM goes to IDLE.
  - quotient, remainder, BUSY, DONE, ERR, counter and internal registers all clear to 0.
  - Reset during CALC aborts the operation; no DONE is produced.
- States: IDLE, LOAD, CALC, DONE_ST.
- IDLE:
  - start=1 at an edge (E0) → LOAD. Otherwise stay in IDLE.
- LOAD (edge E1):
  - Register x and y.
  - Partial remainder P (W+1 bits) ← {1'b0, x[2W-1:W]}; shift register S ← x[W-1:0]; counter ← 0.
  - → CALC.
- CALC, one iteration per edge (E2..E9, W=8 iterations):
  - T = {P[W-1:0], S[W-1]} − {1'b0, y}, computed W+2 bits wide.
  - If T ≥ 0: P ← T and shift 1 into the quotient register Qr.
  - Otherwise: P ← {P[W-1:0], S[W-1]} (restore) and shift 0 into Qr.
  - S shifts left by one.
  - At the edge where counter = W-1:
    - quotient ← final Qr value, remainder ← final P[W-1:0];
    - → DONE_ST.
- DONE_ST:
  - DONE=1 for exactly one cycle (the cycle after E9), then → IDLE.
  - Latency from the start-sampling edge E0 to DONE high is 9 edges.
  - Holding start high gives back-to-back operations, one every 11 cycles.
- quotient/remainder change only on the completion edge. They hold their previous values through LOAD/CALC and until the next completion.
- Changes on x/y after E1 are ignored.
- start during LOAD/CALC/DONE_ST is ignored: no queueing, no restart.
- Arithmetic is unsigned. The trial subtraction must not truncate the carry of the 9-bit shifted value.

Optional Feature:
- Macro DIV_OVF_CHECK_EN, defined:
  - In LOAD, the block detects x[2W-1:W] ≥ y, which includes y=0.
  - On detection: skip CALC; quotient ← all ones; remainder ← 0; ERR=1 during DONE_ST.
  - DONE arrives on E2, giving latency 2 for this case.
  - ERR=0 for every other operation.
- Not defined:
  - ERR is tied to 0 and CALC always runs.
  - quotient/remainder for overflowing inputs are unspecified.
  - Latency stays at 9, and FSM/handshake behaviour is unchanged.

Decomposition:
- Package div_pkg holds:
  - the state enum: IDLE=2'b00, LOAD=2'b01, CALC=2'b10, DONE_ST=2'b11;
  - constants W=8 and CNT_W=4.
- One sub-module, divider16by8_fd (datapath), contains:
  - the operand, P, S and Qr registers;
  - the subtractor and the result registers.
- It is driven by load/iterate/commit strobes from the top-level FSM, matching the codebase's control-unit/datapath split.

Test Plan:
- x=350, y=14, start pulsed one cycle → DONE exactly 9 edges later; quotient=25, remainder=0, ERR=0.
- x=355, y=14 → quotient=25, remainder=5. Then x=4000, y=200 → quotient=20, remainder=0. Then x=0, y=7 → quotient=0, remainder=0.
- start held high, x=255, y=16 → back-to-back results quotient=15, remainder=15 every 11 cycles; DONE is a single-cycle pulse each time; BUSY is low only in IDLE.
- Start an operation, then change x/y and toggle start during CALC → result is for the original operands; exactly one DONE.
- Assert RESET_N=0 mid-CALC (after 4 iterations) → all outputs 0 immediately, without waiting for a clock edge; no DONE; a new op x=100, y=9 afterwards gives quotient=11, remainder=1.
- With DIV_OVF_CHECK_EN: y=0, x=1234 → DONE at E2, ERR=1, quotient=255, remainder=0. x=65535, y=255 → ERR=1. Without the macro: ERR stays 0 and latency stays 9.
